sv_tlb: RTL

- Parametrised, fully-associative translation lookaside buffer for the Sv32 MMU path between the CPU bus port and the Cache/BRAM bus controller.
- Translates a 32-bit virtual address to a physical address in one registered cycle.
- Checks R/W/X/U permissions and supports 4 KiB pages and 4 MiB megapages, ASIDs and global entries.
- Is refilled by the page-table walker and supports sfence.vma-style flushes (all, by VA, by ASID, by both).

---
 rtl/sv_tlb_if.sv | 53 +++++
 rtl/sv_tlb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sv_tlb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sv_tlb_if : lookup / refill / flush / statistics bundle of sv_tlb   |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
interface sv_tlb_if #(
  parameter int VPN_BITS  = 20,
  parameter int PPN_BITS  = 20,
  parameter int ASID_BITS = 9,
  parameter int CNT_BITS  = 32
);
  logic                   lk_valid;
  logic [VPN_BITS+11:0]   lk_va;
  logic [ASID_BITS-1:0]   lk_asid;
  logic [1:0]             lk_acc;
  logic                   lk_user;
  logic                   lk_sum;

  logic                   rsp_valid;
  logic                   rsp_hit;
  logic                   rsp_fault;
  logic [PPN_BITS+11:0]   rsp_pa;

  logic                   fill_valid;
  logic [VPN_BITS-1:0]    fill_vpn;
  logic [PPN_BITS-1:0]    fill_ppn;
  logic [ASID_BITS-1:0]   fill_asid;
  logic [5:0]             fill_perm;

  logic                   flush_valid;
  logic                   flush_va_en;
  logic [VPN_BITS-1:0]    flush_vpn;
  logic                   flush_asid_en;
  logic [ASID_BITS-1:0]   flush_asid;

  logic [CNT_BITS-1:0]    hit_cnt;
  logic [CNT_BITS-1:0]    miss_cnt;

  modport master (
    output lk_valid, lk_va, lk_asid, lk_acc, lk_user, lk_sum,
    output fill_valid, fill_vpn, fill_ppn, fill_asid, fill_perm,
    output flush_valid, flush_va_en, flush_vpn, flush_asid_en, flush_asid,
    input  rsp_valid, rsp_hit, rsp_fault, rsp_pa, hit_cnt, miss_cnt
  );

  modport slave (
    input  lk_valid, lk_va, lk_asid, lk_acc, lk_user, lk_sum,
    input  fill_valid, fill_vpn, fill_ppn, fill_asid, fill_perm,
    input  flush_valid, flush_va_en, flush_vpn, flush_asid_en, flush_asid,
    output rsp_valid, rsp_hit, rsp_fault, rsp_pa, hit_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sv_tlb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sv_tlb : fully-associative Sv32 TLB, 1-cycle registered lookup      |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module sv_tlb #(
  parameter int TLB_ENTRIES = 8,
  parameter int VPN_BITS    = 20,
  parameter int PPN_BITS    = 20,
  parameter int ASID_BITS   = 9,
  parameter int CNT_BITS    = 32
) (
  input wire logic clk,
  input wire logic reset,
  sv_tlb_if.slave  bus
);
  localparam int c_idx_w  = $clog2(TLB_ENTRIES);
  localparam int c_pa_w   = PPN_BITS + 12;
  localparam int c_p_r    = 0;
  localparam int c_p_w    = 1;
  localparam int c_p_x    = 2;
  localparam int c_p_u    = 3;
  localparam int c_p_g    = 4;
  localparam int c_p_mega = 5;

  logic [TLB_ENTRIES-1:0] r_valid;
  logic [VPN_BITS-1:0]    r_vpn  [TLB_ENTRIES];
  logic [PPN_BITS-1:0]    r_ppn  [TLB_ENTRIES];
  logic [ASID_BITS-1:0]   r_asid [TLB_ENTRIES];
  logic [5:0]             r_perm [TLB_ENTRIES];
  logic [c_idx_w-1:0]     r_rr;

  logic                   r_rsp_valid;
  logic                   r_rsp_hit;
  logic                   r_rsp_fault;
  logic [c_pa_w-1:0]      r_rsp_pa;
  logic [CNT_BITS-1:0]    r_hit_cnt;
  logic [CNT_BITS-1:0]    r_miss_cnt;

  logic [TLB_ENTRIES-1:0] w_lk_match;
  logic [TLB_ENTRIES-1:0] w_flush_kill;
  logic [TLB_ENTRIES-1:0] w_valid_post;
  logic [TLB_ENTRIES-1:0] w_fill_same;

  generate
    for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_entry
      logic w_mega;
      logic w_lk_va_eq;
      logic w_fl_va_eq;
      assign w_mega     = r_perm[gi][c_p_mega];
      assign w_lk_va_eq = w_mega ? (r_vpn[gi][VPN_BITS-1:10] == bus.lk_va[VPN_BITS+11:22])
                                 : (r_vpn[gi] == bus.lk_va[VPN_BITS+11:12]);
      assign w_fl_va_eq = w_mega ? (r_vpn[gi][VPN_BITS-1:10] == bus.flush_vpn[VPN_BITS-1:10])
                                 : (r_vpn[gi] == bus.flush_vpn);
      assign w_lk_match[gi] = r_valid[gi] && w_lk_va_eq &&
                              (r_perm[gi][c_p_g] || (r_asid[gi] == bus.lk_asid));
      assign w_flush_kill[gi] = bus.flush_valid && r_valid[gi] &&
                                (!bus.flush_va_en || w_fl_va_eq) &&
                                (!bus.flush_asid_en ||
                                 ((r_asid[gi] == bus.flush_asid) && !r_perm[gi][c_p_g]));
      assign w_valid_post[gi] = r_valid[gi] && !w_flush_kill[gi];
      // Refill target search sees the table as it stands after any same-cycle flush.
      assign w_fill_same[gi] = w_valid_post[gi] && (r_vpn[gi] == bus.fill_vpn) &&
                               (w_mega == bus.fill_perm[c_p_mega]) &&
                               (r_perm[gi][c_p_g] || (r_asid[gi] == bus.fill_asid));
    end
  endgenerate

  logic               w_lk_hit;
  logic [c_idx_w-1:0] w_lk_idx;
  logic               w_same_hit;
  logic [c_idx_w-1:0] w_same_idx;
  logic               w_free_hit;
  logic [c_idx_w-1:0] w_free_idx;

  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_idx   = '0;
    w_same_hit = 1'b0;
    w_same_idx = '0;
    w_free_hit = 1'b0;
    w_free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (w_lk_match[i]) begin
        w_lk_hit = 1'b1;
        w_lk_idx = c_idx_w'(i);
      end
      if (w_fill_same[i]) begin
        w_same_hit = 1'b1;
        w_same_idx = c_idx_w'(i);
      end
      if (!w_valid_post[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = c_idx_w'(i);
      end
    end
  end

  logic [c_idx_w-1:0] w_fill_idx;
  logic               w_evict;

  always_comb begin
    w_evict    = 1'b0;
    w_fill_idx = r_rr;
    if (w_same_hit) begin
      w_fill_idx = w_same_idx;
    end else if (w_free_hit) begin
      w_fill_idx = w_free_idx;
    end else begin
      w_evict = 1'b1;
    end
  end

  logic [5:0]          w_sel_perm;
  logic [PPN_BITS-1:0] w_sel_ppn;
  logic                w_acc_ok;
  logic                w_fault;
  logic [c_pa_w-1:0]   w_pa;

  assign w_sel_perm = r_perm[w_lk_idx];
  assign w_sel_ppn  = r_ppn[w_lk_idx];

  always_comb begin
    case (bus.lk_acc)
      2'b00:   w_acc_ok = w_sel_perm[c_p_r];
      2'b01:   w_acc_ok = w_sel_perm[c_p_w];
      default: w_acc_ok = w_sel_perm[c_p_x];
    endcase
  end

  // Supervisor may touch U pages only for data and only with SUM set.
  assign w_fault = !w_acc_ok ||
                   (bus.lk_user && !w_sel_perm[c_p_u]) ||
                   (!bus.lk_user && w_sel_perm[c_p_u] && (bus.lk_acc[1] || !bus.lk_sum));

  assign w_pa = w_sel_perm[c_p_mega] ? {w_sel_ppn[PPN_BITS-1:10], bus.lk_va[21:0]}
                                     : {w_sel_ppn, bus.lk_va[11:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_rr    <= '0;
    end else begin
      r_valid <= w_valid_post;
      if (bus.fill_valid) begin
        r_valid[w_fill_idx] <= 1'b1;
        r_vpn[w_fill_idx]   <= bus.fill_vpn;
        r_ppn[w_fill_idx]   <= bus.fill_ppn;
        r_asid[w_fill_idx]  <= bus.fill_asid;
        r_perm[w_fill_idx]  <= bus.fill_perm;
        if (w_evict) begin
          r_rr <= r_rr + c_idx_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_pa    <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_rsp_valid <= bus.lk_valid;
      r_rsp_hit   <= bus.lk_valid && w_lk_hit;
      r_rsp_fault <= bus.lk_valid && w_lk_hit && w_fault;
      r_rsp_pa    <= (bus.lk_valid && w_lk_hit) ? w_pa : '0;
      if (bus.lk_valid) begin
        if (w_lk_hit) begin
          if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_BITS'(1);
        end else begin
          if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_BITS'(1);
        end
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_hit   = r_rsp_hit;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.rsp_pa    = r_rsp_pa;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;
endmodule
`default_nettype wire
